ex_stage: RTL and testbench

- Execute stage of the Sirius five-stage MIPS pipeline. It is the consuming end of the decode-stage outputs: aluop, alusel, reg1, reg2, wd and wreg.
- Computes single-cycle logic, shift, arithmetic and HI/LO move results, and registers the write-back triple toward MEM.
- Owns the HI/LO registers and a 32-iteration radix-2 sequential divider for DIV/DIVU. It raises a stall request upstream while a divide is in flight.

---
 rtl/ex_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the Sirius five-stage MIPS pipeline.
// Single-cycle logic/shift/arith/move results are registered toward MEM.
// Owns HI/LO and a radix-2 restoring divider for DIV/DIVU; stalls
// upstream while a divide is in flight.
module ex_stage #(
  parameter logic [31:0] DIV_ZERO_Q    = 32'hFFFF_FFFF,
  parameter bit          DIV_ZERO_FAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  // Result classes
  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;
  localparam logic [2:0] RES_ARITH = 3'b100;

  // Operation subtypes
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_MFHI = 8'b0001_0000;
  localparam logic [7:0] OP_MFLO = 8'b0001_0010;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_dvd;     // dividend shifting out, quotient shifting in
  logic [31:0] r_dvs;     // divisor magnitude
  logic [31:0] r_rem;     // partial remainder
  logic [31:0] r_raw1;    // raw dividend, used as remainder for divide-by-zero
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_zero;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [4:0]  r_wd;
  logic        r_wreg;
  logic [31:0] r_wdata;

  logic        w_is_div;
  logic        w_signed;
  logic        w_dvs_zero;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic        w_stall;
  logic [31:0] w_result;

  assign w_is_div   = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign w_signed   = (aluop_i == OP_DIV);
  assign w_dvs_zero = (reg2_i == 32'd0);
  assign w_a_neg    = w_signed & reg1_i[31];
  assign w_b_neg    = w_signed & reg2_i[31];
  assign w_abs_a    = w_a_neg ? (32'd0 - reg1_i) : reg1_i;
  assign w_abs_b    = w_b_neg ? (32'd0 - reg2_i) : reg2_i;

  // Shift-subtract step: the remainder can never exceed the divisor, so the
  // low 32 bits of the difference are exact whenever the subtraction is taken.
  assign w_shift = {r_rem, r_dvd[31]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[31:0] - r_dvs;

  // Sign fixup: quotient negated on differing signs, remainder follows dividend.
  assign w_q = r_zero ? DIV_ZERO_Q : (r_neg_q ? (32'd0 - r_dvd) : r_dvd);
  assign w_r = r_zero ? r_raw1     : (r_neg_r ? (32'd0 - r_rem) : r_rem);

  // Stall request: any divide held in IDLE or iterating in BUSY holds upstream.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:  w_stall = w_is_div;
      S_BUSY:  w_stall = 1'b1;
      S_DONE:  w_stall = 1'b0;
      default: w_stall = 1'b0;
    endcase
  end

  // Single-cycle result selection by class and subtype.
  always_comb begin
    w_result = 32'd0;
    case (alusel_i)
      RES_LOGIC: begin
        case (aluop_i)
          OP_OR:   w_result = reg1_i | reg2_i;
          OP_AND:  w_result = reg1_i & reg2_i;
          OP_XOR:  w_result = reg1_i ^ reg2_i;
          OP_NOR:  w_result = ~(reg1_i | reg2_i);
          default: w_result = 32'd0;
        endcase
      end
      RES_SHIFT: begin
        case (aluop_i)
          OP_SLL:  w_result = reg2_i << reg1_i[4:0];
          OP_SRL:  w_result = reg2_i >> reg1_i[4:0];
          OP_SRA:  w_result = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
          default: w_result = 32'd0;
        endcase
      end
      RES_ARITH: begin
        case (aluop_i)
          OP_ADDU: w_result = reg1_i + reg2_i;
          OP_SUBU: w_result = reg1_i - reg2_i;
          OP_SLT:  w_result = ($signed(reg1_i) < $signed(reg2_i)) ? 32'd1 : 32'd0;
          OP_SLTU: w_result = (reg1_i < reg2_i) ? 32'd1 : 32'd0;
          default: w_result = 32'd0;
        endcase
      end
      RES_MOVE: begin
        case (aluop_i)
          OP_MFHI: w_result = r_hi;
          OP_MFLO: w_result = r_lo;
          default: w_result = 32'd0;
        endcase
      end
      RES_NOP: w_result = 32'd0;
      default: w_result = 32'd0;
    endcase
  end

  // Divider FSM and HI/LO ownership; reset aborts any divide in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_dvd   <= 32'd0;
      r_dvs   <= 32'd0;
      r_rem   <= 32'd0;
      r_raw1  <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_div) begin
            r_raw1 <= reg1_i;
            r_zero <= w_dvs_zero;
            r_cnt  <= 5'd0;
            if (w_dvs_zero && DIV_ZERO_FAST) begin
              r_state <= S_DONE;
            end else begin
              r_dvd   <= w_abs_a;
              r_dvs   <= w_abs_b;
              r_rem   <= 32'd0;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_state <= S_BUSY;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (w_ge) begin
            r_rem <= w_diff;
            r_dvd <= {r_dvd[30:0], 1'b1};
          end else begin
            r_rem <= w_shift[31:0];
            r_dvd <= {r_dvd[30:0], 1'b0};
          end
          if (r_cnt == 5'd31) begin
            r_cnt   <= 5'd0;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 5'd1;
          end
        end
        S_DONE: begin
          r_lo    <= w_q;
          r_hi    <= w_r;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write-back triple toward MEM; bubbles while stalled, divides never write a GPR.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wd    <= 5'd0;
      r_wreg  <= 1'b0;
      r_wdata <= 32'd0;
    end else begin
      r_wd <= wd_i;
      if (w_stall) begin
        r_wreg  <= 1'b0;
        r_wdata <= 32'd0;
      end else begin
        r_wreg  <= wreg_i & ~w_is_div;
        r_wdata <= w_result;
      end
    end
  end

  assign wd_o       = r_wd;
  assign wreg_o     = r_wreg;
  assign wdata_o    = r_wdata;
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;
  assign stallreq_o = w_stall;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage with a scoreboard queue.
module tb_ex_stage;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;
  localparam logic [2:0] RES_ARITH = 3'b100;

  localparam logic [7:0] OP_NOP  = 8'b0000_0000;
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_MFHI = 8'b0001_0000;
  localparam logic [7:0] OP_MFLO = 8'b0001_0010;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  typedef struct {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
  } exp_t;

  exp_t        sb[$];
  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          s0;
  int          s1;
  int          s2;

  ex_stage #(.DIV_ZERO_Q(32'hFFFF_FFFF), .DIV_ZERO_FAST(1'b1)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wr);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
    wd_i     = wd;
    wreg_i   = wr;
  endtask

  // Single-cycle op: push expectation at drive time, pop after the edge.
  task automatic issue(input string tag, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wr, input logic [31:0] expv);
    exp_t e;
    drive(op, sel, a, b, wd, wr);
    e.wdata = expv;
    e.wd    = wd;
    e.wreg  = wr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".wdata"}, wdata_o, e.wdata);
    chk({tag, ".wd"}, {27'd0, wd_o}, {27'd0, e.wd});
    chk({tag, ".wreg"}, {31'd0, wreg_o}, {31'd0, e.wreg});
  endtask

  // Divide: count stalled cycles, check bubbles, then HI/LO after leaving DONE.
  task automatic run_div(input string tag, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output int stalls);
    logic signed [31:0] sa;
    logic signed [31:0] sb_;
    logic [31:0] eq;
    logic [31:0] er;
    int          exp_st;
    bit          wbad;
    sa  = a;
    sb_ = b;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
      exp_st = 1;
    end else if (op == OP_DIV) begin
      eq = sa / sb_;
      er = sa % sb_;
      exp_st = 33;
    end else begin
      eq = a / b;
      er = a % b;
      exp_st = 33;
    end
    drive(op, RES_NOP, a, b, 5'd3, 1'b1);
    #1;
    stalls = 0;
    wbad   = 1'b0;
    while (stallreq_o === 1'b1 && stalls < 200) begin
      stalls++;
      @(posedge clk);
      #1;
      if (wreg_o !== 1'b0) wbad = 1'b1;
      if (scramble && stalls == 2) begin
        reg1_i = $urandom;
        reg2_i = $urandom;
        #1;
      end
    end
    chk({tag, ".stalls"}, stalls, exp_st);
    chk({tag, ".wreg_during_stall"}, {31'd0, wbad}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, ".wreg_done"}, {31'd0, wreg_o}, 32'd0);
    chk({tag, ".lo"}, lo_o, eq);
    chk({tag, ".hi"}, hi_o, er);
    m_lo = eq;
    m_hi = er;
  endtask

  initial begin
    m_hi = 32'd0;
    m_lo = 32'd0;
    rst  = 1'b0;
    drive(OP_OR, RES_LOGIC, 32'h0000_1100, 32'h0000_0011, 5'd5, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.wd", {27'd0, wd_o}, 32'd0);
    chk("rst.wreg", {31'd0, wreg_o}, 32'd0);
    chk("rst.wdata", wdata_o, 32'd0);
    chk("rst.hi", hi_o, 32'd0);
    chk("rst.lo", lo_o, 32'd0);
    chk("rst.stall", {31'd0, stallreq_o}, 32'd0);
    rst = 1'b1;

    issue("or",   OP_OR,   RES_LOGIC, 32'h0000_1100, 32'h0000_0011, 5'd5,  1'b1, 32'h0000_1111);
    issue("and",  OP_AND,  RES_LOGIC, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd6,  1'b1, 32'h00F0_F000);
    issue("xor",  OP_XOR,  RES_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 5'd7,  1'b0, 32'h5555_5555);
    issue("nor",  OP_NOR,  RES_LOGIC, 32'h0000_00F0, 32'h0000_000F, 5'd8,  1'b1, 32'hFFFF_FF00);
    issue("sra",  OP_SRA,  RES_SHIFT, 32'd4,         32'h8000_0000, 5'd9,  1'b1, 32'hF800_0000);
    issue("srl",  OP_SRL,  RES_SHIFT, 32'd4,         32'h8000_0000, 5'd10, 1'b1, 32'h0800_0000);
    issue("sll",  OP_SLL,  RES_SHIFT, 32'd35,        32'h0000_0001, 5'd11, 1'b1, 32'h0000_0008);
    issue("slt",  OP_SLT,  RES_ARITH, 32'hFFFF_FFFF, 32'd1,         5'd12, 1'b1, 32'd1);
    issue("sltu", OP_SLTU, RES_ARITH, 32'hFFFF_FFFF, 32'd1,         5'd13, 1'b1, 32'd0);
    issue("addu", OP_ADDU, RES_ARITH, 32'hFFFF_FFFF, 32'd2,         5'd14, 1'b1, 32'd1);
    issue("subu", OP_SUBU, RES_ARITH, 32'd1,         32'd2,         5'd15, 1'b1, 32'hFFFF_FFFF);
    issue("nop",  OP_NOP,  RES_NOP,   32'h1234_5678, 32'h9ABC_DEF0, 5'd16, 1'b1, 32'd0);
    issue("badsel", OP_OR, 3'b111,    32'h1234_5678, 32'h9ABC_DEF0, 5'd17, 1'b1, 32'd0);

    run_div("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, s0);
    issue("mflo_after_div", OP_MFLO, RES_MOVE, 32'd0, 32'd0, 5'd2, 1'b1, m_lo);
    issue("mfhi_after_div", OP_MFHI, RES_MOVE, 32'd0, 32'd0, 5'd4, 1'b1, m_hi);
    chk("div_neg.lo_const", m_lo, 32'hFFFF_FFFD);

    run_div("divu_zero", OP_DIVU, 32'hFFFF_FFFF, 32'd0, 1'b0, s0);

    drive(OP_DIVU, RES_NOP, 32'd100, 32'd7, 5'd3, 1'b1);
    repeat (11) @(posedge clk);
    #1;
    chk("abort.busy_stall", {31'd0, stallreq_o}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(OP_NOP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    #1;
    chk("abort.stall", {31'd0, stallreq_o}, 32'd0);
    chk("abort.hi", hi_o, 32'd0);
    chk("abort.lo", lo_o, 32'd0);
    @(posedge clk);
    #1;
    chk("abort.idle_hi", hi_o, 32'd0);

    run_div("divu_reissue", OP_DIVU, 32'd100, 32'd7, 1'b0, s0);
    chk("divu_reissue.lo_const", lo_o, 32'd14);

    run_div("b2b_first", OP_DIVU, 32'd100, 32'd7, 1'b0, s1);
    run_div("b2b_second", OP_DIVU, 32'd9, 32'd3, 1'b1, s2);
    chk("b2b.total_stalls", s1 + s2, 32'd66);
    issue("mflo_b2b", OP_MFLO, RES_MOVE, 32'd0, 32'd0, 5'd20, 1'b1, 32'd3);
    issue("mfhi_b2b", OP_MFHI, RES_MOVE, 32'd0, 32'd0, 5'd21, 1'b1, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
